// File: rtl/hourglass_timer_pkg.sv
// Shared types and defaults for the hourglass countdown controller.
// The state enum is common to the top-level FSM and any debug/observation logic.
package hourglass_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned CLK_DIV_DEFAULT = 50000000;
  localparam int unsigned DUR_W_DEFAULT   = 8;

endpackage

// File: rtl/hg_prescaler.sv
// Divides the system clock into a one-cycle tick every CLK_DIV cycles (CLK_DIV >= 2).
// wrap flags the terminal-count cycle so the owner can act on the same edge the tick is launched.
module hg_prescaler
  import hourglass_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic sync_clr,
  output logic tick,
  output logic wrap
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q;

  assign wrap = !sync_clr && !hold && (count_q == LAST);
  assign tick = tick_q;

  always_comb begin
    count_d = count_q;
    if (sync_clr) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= wrap;
    end
  end

endmodule

// File: rtl/hourglass_timer.sv
// Hourglass countdown controller: loads a duration, counts it down once per second,
// and holds the melody stage in reset (alarm_rst) until the sand runs out.
module hourglass_timer
  import hourglass_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  parameter int unsigned DUR_W   = DUR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [DUR_W-1:0] duration,
  output logic             sec_tick,
  output logic [DUR_W-1:0] remaining,
  output logic             running,
  output logic             expired,
  output logic             alarm_rst
);

  state_e           state_q, state_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic             running_q, expired_q, alarm_rst_q;
  logic             presHold, presClr, presWrap, tickDec;

  // The prescaler only freezes while pause is actually high, so a pause of N cycles
  // delays expiry by exactly N cycles, including the release cycle out of PAUSE.
  assign presHold = pause && (state_q == RUN || state_q == PAUSE);
  assign presClr  = clear || start;
  assign tickDec  = presWrap && (state_q == RUN || state_q == PAUSE);

  hg_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (presHold),
    .sync_clr (presClr),
    .tick     (sec_tick),
    .wrap     (presWrap)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (clear) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      remaining_d = duration;
      state_d     = (duration == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN:     if (pause) state_d = PAUSE;
        PAUSE:   if (!pause) state_d = RUN;
        DONE:    remaining_d = '0;
        default: ;
      endcase
      if (tickDec) begin
        if (remaining_q > DUR_W'(1)) begin
          remaining_d = remaining_q - 1'b1;
        end else begin
          remaining_d = '0;
          state_d     = DONE;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      alarm_rst_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      running_q   <= (state_d == RUN);
      expired_q   <= (state_d == DONE);
      alarm_rst_q <= (state_d != DONE);
    end
  end

  assign remaining = remaining_q;
  assign running   = running_q;
  assign expired   = expired_q;
  assign alarm_rst = alarm_rst_q;

endmodule

// File: tb/tb_hourglass_timer.sv
// Directed bench for hourglass_timer with CLK_DIV=4: expectations are queued with the
// cycle they fall due and compared by a monitor one time unit after each rising edge.
module tb_hourglass_timer;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DUR_W   = 8;

  localparam logic [11:0] M_ALL  = 12'hFFF;
  localparam logic [11:0] M_TICK = 12'h001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, pause, clear;
  logic [DUR_W-1:0] duration;
  logic             secTick, running, expired, alarmRst;
  logic [DUR_W-1:0] remaining;

  typedef struct {
    int          due;
    string       tag;
    logic [11:0] expVal;
    logic [11:0] mask;
  } expT;

  expT sbQ[$];
  int  cyc        = 0;
  int  compared   = 0;
  int  mismatched = 0;

  hourglass_timer #(
    .CLK_DIV (CLK_DIV),
    .DUR_W   (DUR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .duration  (duration),
    .sec_tick  (secTick),
    .remaining (remaining),
    .running   (running),
    .expired   (expired),
    .alarm_rst (alarmRst)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] packObs(logic [7:0] r, logic run, logic ex, logic ar, logic tk);
    return {r, run, ex, ar, tk};
  endfunction

  task automatic checkOutput(input expT e);
    logic [11:0] obs;
    obs = {remaining, running, expired, alarmRst, secTick};
    compared++;
    assert ((obs & e.mask) === (e.expVal & e.mask)) else begin
      mismatched++;
      $error("[TB] FAIL %s @cyc %0d: observed rem=%0d run=%b exp=%b arst=%b tick=%b, expected rem=%0d run=%b exp=%b arst=%b tick=%b (mask %h)",
             e.tag, cyc, obs[11:4], obs[3], obs[2], obs[1], obs[0],
             e.expVal[11:4], e.expVal[3], e.expVal[2], e.expVal[1], e.expVal[0], e.mask);
    end
  endtask

  task automatic pushExp(input int due, input string tag, input logic [7:0] r, input logic run,
                         input logic ex, input logic ar, input logic tk, input logic [11:0] m);
    expT e;
    int  i;
    e.due    = due;
    e.tag    = tag;
    e.expVal = packObs(r, run, ex, ar, tk);
    e.mask   = m;
    i = 0;
    while (i < sbQ.size() && sbQ[i].due <= due) i++;
    sbQ.insert(i, e);
  endtask

  task automatic directCheck(input string tag, input logic [7:0] r, input logic run,
                             input logic ex, input logic ar, input logic tk);
    expT e;
    e.due    = cyc;
    e.tag    = tag;
    e.expVal = packObs(r, run, ex, ar, tk);
    e.mask   = M_ALL;
    checkOutput(e);
  endtask

  task automatic applyStimulus(input logic st, input logic ps, input logic cl, input logic [7:0] dur);
    start    = st;
    pause    = ps;
    clear    = cl;
    duration = dur;
  endtask

  task automatic waitUntil(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(posedge clk) begin : monitor
    expT e;
    #1;
    cyc++;
    while (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
      e = sbQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed cyc=%0d expected < 1000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int b;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    directCheck("reset_values", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic countdown from 3, then free-running tick while DONE
    b = cyc + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3);
    pushExp(b,      "s1_load",    8'd3, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 3,  "s1_hold3",   8'd3, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 4,  "s1_dec2",    8'd2, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    pushExp(b + 8,  "s1_dec1",    8'd1, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    pushExp(b + 12, "s1_expire",  8'd0, 1'b0, 1'b1, 1'b0, 1'b1, M_ALL);
    pushExp(b + 13, "s4_done_t0", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, M_ALL);
    pushExp(b + 14, "s4_tick_lo", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, M_TICK);
    pushExp(b + 15, "s4_tick_lo", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, M_TICK);
    pushExp(b + 16, "s4_tick_hi", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, M_ALL);
    pushExp(b + 17, "s4_tick_lo", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, M_TICK);
    pushExp(b + 20, "s4_tick_hi", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, M_ALL);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd3);
    waitUntil(b + 20);

    // Clear from DONE, then restart with duration 2
    b = cyc + 1;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    pushExp(b, "s4_clear", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL);
    @(negedge clk);
    b = cyc + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd2);
    pushExp(b,     "s4_restart", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 4, "s4_dec1",    8'd1, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd2);
    waitUntil(b + 4);

    // Zero duration goes straight to DONE with no RUN cycle
    b = cyc + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    pushExp(b,     "s2_zero_done", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, M_ALL);
    pushExp(b + 1, "s2_zero_stay", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, M_ALL);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    waitUntil(b + 1);

    // Pause for 10 cycles with the prescaler at residue 2: expiry moves from b+20 to b+30
    b = cyc + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd5);
    pushExp(b,      "s3_load",      8'd5, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 4,  "s3_dec4",      8'd4, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    pushExp(b + 7,  "s3_paused",    8'd4, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 12, "s3_paused",    8'd4, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 16, "s3_paused",    8'd4, 1'b0, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 17, "s3_resumed",   8'd4, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 18, "s3_residue",   8'd3, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    pushExp(b + 20, "s3_not_yet",   8'd3, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 22, "s3_dec2",      8'd2, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    pushExp(b + 26, "s3_dec1",      8'd1, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    pushExp(b + 29, "s3_pre_exp",   8'd1, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 30, "s3_expire",    8'd0, 1'b0, 1'b1, 1'b0, 1'b1, M_ALL);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd5);
    waitUntil(b + 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd5);
    waitUntil(b + 16);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd5);
    waitUntil(b + 30);

    // Reload lands on the terminal-count cycle: reload wins, prescaler restarts
    b = cyc + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3);
    pushExp(b,      "s5_load",     8'd3, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 4,  "s5_dec2",     8'd2, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    pushExp(b + 8,  "s5_reload7",  8'd7, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 11, "s5_hold7",    8'd7, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    pushExp(b + 12, "s5_dec6",     8'd6, 1'b1, 1'b0, 1'b1, 1'b1, M_ALL);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd3);
    waitUntil(b + 7);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd7);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd7);
    waitUntil(b + 12);

    // Asynchronous reset mid-count, checked between clock edges
    b = cyc + 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3);
    pushExp(b + 2, "s6_mid", 8'd3, 1'b1, 1'b0, 1'b1, 1'b0, M_ALL);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd3);
    waitUntil(b + 2);
    #2;
    rst_n = 1'b0;
    #1;
    directCheck("s6_async_rst", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    directCheck("s6_rst_held", 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    compared++;
    assert (sbQ.size() == 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending, expected 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hourglass_timer.md
Name: hourglass_timer

Overview:
Countdown controller that sits directly upstream of the melody/beeper stage in the electronic hourglass. It divides the system clock into a one-second tick, counts the user-loaded sand duration down to zero, and holds the melody stage in reset until expiry. On expiry it releases that reset, so the alarm tune plays from its first note, paced by this block's tick.

Parameters:
CLK_DIV, 50000000, system clock cycles per one-second tick; must be >= 2.
DUR_W, 8, width of the duration and remaining-seconds fields.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled each cycle; loads duration and starts or restarts the countdown
pause  input  1  level; while high in RUN, countdown and prescaler freeze
clear  input  1  level; returns to IDLE and silences the alarm
duration  input  DUR_W  countdown length in seconds, sampled when start is accepted
sec_tick  output  1  one-cycle pulse once per CLK_DIV cycles; drives the melody stage's note clock
remaining  output  DUR_W  seconds left
running  output  1  high in RUN
expired  output  1  high in DONE
alarm_rst  output  1  active-high reset to the melody stage; low only in DONE

Behaviour:
- Reset (rst_n low, asynchronous) drives the following values:
  - state = IDLE, prescaler = 0, remaining = 0.
  - sec_tick = 0, running = 0, expired = 0, alarm_rst = 1.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - sec_tick is a registered pulse, high for the single cycle after the prescaler reaches CLK_DIV-1.
  - Free-running in IDLE and DONE, so the melody keeps its pace.
  - Holds its value in PAUSE.
  - Forced to 0 on any accepted start or clear.
- Input priority, evaluated each cycle: clear > start > pause > tick-decrement.
- States:
  - IDLE:
    - start with duration != 0 -> remaining = duration, go to RUN.
    - start with duration == 0 -> remaining = 0, go to DONE.
  - RUN:
    - pause -> PAUSE.
    - sec_tick with remaining > 1 -> remaining decrements by 1.
    - sec_tick with remaining == 1 -> remaining = 0, go to DONE.
  - PAUSE:
    - pause low -> RUN; prescaler resumes from its held value.
    - No decrement occurs in PAUSE.
  - DONE:
    - remaining stays 0.
    - alarm_rst = 0 for as long as the block stays in DONE.
  - Any state:
    - start (without clear) -> reload from duration, prescaler = 0, go to RUN (or DONE if duration == 0).
    - clear -> IDLE, remaining = 0.
- start is level-sensitive. Holding it high keeps reloading, and no countdown progresses until it drops.
- First decrement latency: exactly CLK_DIV cycles after the cycle in which start is sampled, absent pause.
- Outputs:
  - running, expired and alarm_rst are registered and decoded from state.
  - alarm_rst goes low in the same cycle expired goes high.
- remaining never wraps below 0; a decrement at 0 is impossible by construction.
- Simultaneous events:
  - start and sec_tick in the same cycle -> reload wins, no decrement.
  - pause and sec_tick in the same cycle in RUN -> pause wins, no decrement.
- Reset mid-countdown aborts immediately and re-asserts alarm_rst.

Decomposition:
- The shared package holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the default CLK_DIV constant;
  - the DUR_W default.
- One natural sub-module: hg_prescaler. It takes clk, rst_n, hold and sync_clr, and outputs tick; CLK_DIV is its parameter.
- The FSM and the remaining counter stay in the top module.

Test Plan:
All scenarios use CLK_DIV=4, DUR_W=8.
1. Reset, then start=1 for 1 cycle with duration=3 -> running=1, remaining=3. remaining reads 2, 1, 0 at 4, 8 and 12 cycles after the start sample. At 0, expired=1, alarm_rst=0, running=0.
2. start with duration=0 -> next cycle expired=1, alarm_rst=0, remaining=0, no RUN cycle.
3. duration=5, start, pause high for 10 cycles after the first decrement (remaining=4):
   - remaining holds 4 and running=0 throughout the pause;
   - after release, the next decrement arrives after the prescaler residue, not a full CLK_DIV;
   - expiry occurs 10 cycles later than in the unpaused run.
4. In DONE, check sec_tick keeps pulsing every 4 cycles. Then assert clear -> IDLE, alarm_rst=1, expired=0. Then start with duration=2 -> RUN, remaining=2.
5. In RUN with remaining=2, assert start on the same cycle as sec_tick with duration=7 -> remaining=7, no decrement, prescaler restarts from 0.
6. Assert rst_n low asynchronously mid-count (remaining=3) -> outputs return to reset values without waiting for a clock edge.
